// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: encodings shared by the ALU sequencer and its datapath.
// Holds FSM states, opcodes, ALU command codes and the decoded control bundle.
package alu_seq_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_EXEC,
    S_HALT
  } state_t;

  localparam logic [3:0] OP_LDA  = 4'h0;
  localparam logic [3:0] OP_CMP  = 4'h1;
  localparam logic [3:0] OP_ADD  = 4'h2;
  localparam logic [3:0] OP_NAND = 4'h3;
  localparam logic [3:0] OP_OUT  = 4'h4;
  localparam logic [3:0] OP_JC   = 4'h5;
  localparam logic [3:0] OP_JZ   = 4'h6;
  localparam logic [3:0] OP_JMP  = 4'h7;
  localparam logic [3:0] OP_HALT = 4'h8;

  localparam logic [2:0] CMD_NOP  = 3'b000;
  localparam logic [2:0] CMD_CMP  = 3'b001;
  localparam logic [2:0] CMD_LDA  = 3'b010;
  localparam logic [2:0] CMD_ADD  = 3'b011;
  localparam logic [2:0] CMD_NAND = 3'b100;

  typedef enum logic [1:0] {
    FL_KEEP,
    FL_ALU,
    FL_CLR
  } flag_sel_t;

  typedef enum logic [1:0] {
    J_NONE,
    J_C,
    J_Z,
    J_ALWAYS
  } jump_sel_t;

  typedef struct packed {
    logic [2:0] command;
    logic       en;
    logic       en1;
    logic       en2;
    flag_sel_t  flag_sel;
    jump_sel_t  jump_sel;
    logic       halt;
  } ctl_t;

  // Opcodes whose low nibble is put on the datapath bus
  function automatic logic uses_operand(input logic [3:0] op);
    return op <= OP_NAND;
  endfunction

endpackage

// File: rtl/seq_decode.sv
// seq_decode: combinational opcode-to-control decode of the instruction register.
// Ports: ir (instruction word) in; ctl (command, enables, flag/jump selects, halt) out.
module seq_decode
  import alu_seq_pkg::*;
(
  input  logic [7:0] ir,
  output ctl_t       ctl
);

  logic [3:0] op;
  assign op = ir[7:4];

  always_comb begin
    ctl          = '0;
    ctl.command  = CMD_NOP;
    ctl.flag_sel = FL_KEEP;
    ctl.jump_sel = J_NONE;
    unique case (1'b1)
      (op == OP_LDA): begin
        ctl.command = CMD_LDA;
        ctl.en      = 1'b1;
        ctl.en1     = 1'b1;
      end
      (op == OP_CMP): begin
        ctl.command  = CMD_CMP;
        ctl.en1      = 1'b1;
        ctl.flag_sel = FL_ALU;
      end
      (op == OP_ADD): begin
        ctl.command  = CMD_ADD;
        ctl.en       = 1'b1;
        ctl.en1      = 1'b1;
        ctl.flag_sel = FL_ALU;
      end
      (op == OP_NAND): begin
        ctl.command  = CMD_NAND;
        ctl.en       = 1'b1;
        ctl.en1      = 1'b1;
        ctl.flag_sel = FL_CLR;
      end
      (op == OP_OUT):  ctl.en2      = 1'b1;
      (op == OP_JC):   ctl.jump_sel = J_C;
      (op == OP_JZ):   ctl.jump_sel = J_Z;
      (op == OP_JMP):  ctl.jump_sel = J_ALWAYS;
      (op == OP_HALT): ctl.halt     = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/alu_sequencer.sv
// alu_sequencer: FETCH/EXEC program sequencer driving an accumulator datapath.
// Ports: Clk, reset, start, instr, carry, exit in; pc, operand, command, En/En1/En2, busy, done out.
module alu_sequencer
  import alu_seq_pkg::*;
(
  input  logic       Clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] instr,
  input  logic       carry,
  input  logic       exit,
  output logic [3:0] pc,
  output logic [3:0] operand,
  output logic [2:0] command,
  output logic       En,
  output logic       En1,
  output logic       En2,
  output logic       busy,
  output logic       done
);

  state_t     state_q, state_d;
  logic [7:0] ir_q;
  logic [3:0] pc_q;
  logic [3:0] opnd_q;
  logic       cf_q, zf_q;
  logic       exec;
  logic       take;
  ctl_t       ctl;

  seq_decode u_dec (
    .ir  (ir_q),
    .ctl (ctl)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE,
      S_HALT:  if (start) state_d = S_FETCH;
      S_FETCH: state_d = S_EXEC;
      S_EXEC:  state_d = ctl.halt ? S_HALT : S_FETCH;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    take = 1'b0;
    unique case (ctl.jump_sel)
      J_NONE:   take = 1'b0;
      J_C:      take = cf_q;
      J_Z:      take = zf_q;
      J_ALWAYS: take = 1'b1;
    endcase
  end

  assign exec    = (state_q == S_EXEC);
  assign command = exec ? ctl.command : CMD_NOP;
  assign En      = exec & ctl.en;
  assign En1     = exec & ctl.en1;
  assign En2     = exec & ctl.en2;
  assign busy    = (state_q == S_FETCH) | exec;
  assign done    = (state_q == S_HALT);
  assign pc      = pc_q;
  assign operand = opnd_q;

  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      ir_q    <= '0;
      pc_q    <= '0;
      opnd_q  <= '0;
      cf_q    <= 1'b0;
      zf_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        S_IDLE,
        S_HALT: begin
          if (start) begin
            pc_q <= '0;
            cf_q <= 1'b0;
            zf_q <= 1'b0;
          end
        end
        S_FETCH: begin
          ir_q <= instr;
          // operand bus only changes for ALU ops; otherwise it holds
          if (uses_operand(instr[7:4])) opnd_q <= instr[3:0];
        end
        S_EXEC: begin
          case (ctl.flag_sel)
            FL_ALU: begin
              cf_q <= carry;
              zf_q <= exit;
            end
            FL_CLR: begin
              cf_q <= 1'b0;
              zf_q <= 1'b0;
            end
            default: ;
          endcase
          if (!ctl.halt) pc_q <= take ? ir_q[3:0] : pc_q + 4'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer: program-ROM vectors with an accumulator model and OUT scoreboard.
// Adds hand sequences for pc wrap, reset mid-EXEC and start while busy.
module tb_alu_sequencer;

  logic       Clk = 1'b0;
  logic       reset;
  logic       start;
  logic [7:0] instr;
  logic       carry;
  logic       exit;
  logic [3:0] pc;
  logic [3:0] operand;
  logic [2:0] command;
  logic       En, En1, En2, busy, done;

  alu_sequencer dut (
    .Clk     (Clk),
    .reset   (reset),
    .start   (start),
    .instr   (instr),
    .carry   (carry),
    .exit    (exit),
    .pc      (pc),
    .operand (operand),
    .command (command),
    .En      (En),
    .En1     (En1),
    .En2     (En2),
    .busy    (busy),
    .done    (done)
  );

  always #5 Clk = ~Clk;

  // program ROM and accumulator datapath model
  logic [7:0] rom [16];
  logic [3:0] acc;
  logic [4:0] alu;

  assign instr = rom[pc];

  always_comb begin
    alu = {1'b0, acc};
    case (command)
      3'b001: alu = {1'b0, acc} - {1'b0, operand};
      3'b010: alu = {1'b0, operand};
      3'b011: alu = {1'b0, acc} + {1'b0, operand};
      3'b100: alu = {1'b0, ~(acc & operand)};
      default: alu = {1'b0, acc};
    endcase
  end

  assign carry = alu[4];
  assign exit  = (alu[3:0] == 4'h0);

  always_ff @(posedge Clk or posedge reset) begin
    if (reset) acc <= 4'h0;
    else if (En) acc <= alu[3:0];
  end

  typedef logic [15:0][7:0] rom_t;

  typedef struct packed {
    rom_t       rom;
    logic       has_out;
    logic [3:0] out_val;
    logic [3:0] exp_pc;
    logic [3:0] exp_acc;
    logic [7:0] exp_cyc;
  } vec_t;

  int         checks = 0;
  int         failures = 0;
  logic [3:0] exp_q [$];
  vec_t       tv [8];

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic rom_t p(input logic [7:0] a, input logic [7:0] b,
                             input logic [7:0] c, input logic [7:0] d,
                             input logic [7:0] e);
    rom_t r;
    r    = {16{8'h80}};
    r[0] = a;
    r[1] = b;
    r[2] = c;
    r[3] = d;
    r[4] = e;
    return r;
  endfunction

  function automatic logic has_x();
    return ^{pc, operand, command, En, En1, En2, busy, done} === 1'bx;
  endfunction

  // scoreboard pop on the OUT strobe, plus bus exclusivity every cycle
  always @(negedge Clk) begin
    if (reset === 1'b0) begin
      checks++;
      if (En1 && En2) begin
        failures++;
        $display("FAIL en_excl: En1=%b En2=%b both high", En1, En2);
      end
      if (En2 === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL out_unexpected: got acc %0h expected no strobe", acc);
        end else begin
          logic [3:0] e;
          e = exp_q.pop_front();
          if (acc !== e || command !== 3'b000) begin
            failures++;
            $display("FAIL out_value: got acc %0h cmd %0b expected %0h cmd 0",
                     acc, command, e);
          end
        end
      end
    end
  end

  task automatic pulse_start();
    @(negedge Clk);
    start = 1'b1;
    @(negedge Clk);
    start = 1'b0;
  endtask

  task automatic run_prog(input int idx, input int glitch);
    vec_t v;
    int   cyc;
    v = tv[idx];
    for (int i = 0; i < 16; i++) rom[i] = v.rom[i];
    if (v.has_out) exp_q.push_back(v.out_val);
    pulse_start();
    cyc = 0;
    while (done !== 1'b1 && cyc < 200) begin
      @(posedge Clk);
      cyc++;
      #1;
      start = (cyc == glitch);
    end
    start = 1'b0;
    if (cyc >= 200) begin
      failures++;
      $display("FAIL v%0d_timeout: got no done expected done", idx);
    end
    @(negedge Clk);
    check($sformatf("v%0d_cycles", idx), cyc, v.exp_cyc);
    check($sformatf("v%0d_pc", idx), pc, v.exp_pc);
    check($sformatf("v%0d_acc", idx), acc, v.exp_acc);
    check($sformatf("v%0d_busy", idx), busy, 0);
    check($sformatf("v%0d_outq", idx), exp_q.size(), 0);
    exp_q.delete();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    rom_t r;
    reset = 1'b1;
    start = 1'b0;
    for (int i = 0; i < 16; i++) rom[i] = 8'h80;

    tv[0] = '{rom: p(8'h03, 8'h25, 8'h40, 8'h80, 8'h80), has_out: 1'b1,
              out_val: 4'h8, exp_pc: 4'd3, exp_acc: 4'h8, exp_cyc: 8'd8};
    tv[1] = '{rom: p(8'h09, 8'h19, 8'h67, 8'h80, 8'h80), has_out: 1'b0,
              out_val: 4'h0, exp_pc: 4'd7, exp_acc: 4'h9, exp_cyc: 8'd8};
    r     = p(8'h65, 8'h02, 8'h7E, 8'h80, 8'h80);
    r[14] = 8'h12;
    r[15] = 8'hF3;
    tv[2] = '{rom: r, has_out: 1'b0,
              out_val: 4'h0, exp_pc: 4'd5, exp_acc: 4'h2, exp_cyc: 8'd14};
    tv[3] = '{rom: p(8'h0C, 8'h27, 8'h5A, 8'h80, 8'h80), has_out: 1'b0,
              out_val: 4'h0, exp_pc: 4'd10, exp_acc: 4'h3, exp_cyc: 8'd8};
    tv[4] = '{rom: p(8'h0C, 8'h22, 8'h5A, 8'h80, 8'h80), has_out: 1'b0,
              out_val: 4'h0, exp_pc: 4'd3, exp_acc: 4'hE, exp_cyc: 8'd8};
    tv[5] = '{rom: p(8'h09, 8'h14, 8'h67, 8'h40, 8'h80), has_out: 1'b1,
              out_val: 4'h9, exp_pc: 4'd4, exp_acc: 4'h9, exp_cyc: 8'd10};
    tv[6] = '{rom: p(8'h0A, 8'h36, 8'h40, 8'h80, 8'h80), has_out: 1'b1,
              out_val: 4'hD, exp_pc: 4'd3, exp_acc: 4'hD, exp_cyc: 8'd8};
    tv[7] = '{rom: p(8'h0F, 8'h21, 8'h30, 8'h57, 8'h80), has_out: 1'b0,
              out_val: 4'h0, exp_pc: 4'd4, exp_acc: 4'hF, exp_cyc: 8'd10};

    #2;
    check("rst_pc", pc, 0);
    check("rst_operand", operand, 0);
    check("rst_command", command, 0);
    check("rst_en", {En, En1, En2}, 0);
    check("rst_busy_done", {busy, done}, 0);
    @(negedge Clk);
    reset = 1'b0;
    repeat (3) @(negedge Clk);
    check("idle_no_start", {busy, done}, 0);

    for (int k = 0; k < 8; k++) run_prog(k, 0);

    // JMP 15, NOP at 15, wrap back to 0
    for (int i = 0; i < 16; i++) rom[i] = 8'h80;
    rom[0]  = 8'h7F;
    rom[15] = 8'h90;
    pulse_start();
    check("wrap_pc0", pc, 0);
    check("wrap_nox0", has_x(), 0);
    repeat (2) @(negedge Clk);
    check("wrap_pc15", pc, 15);
    check("wrap_nox1", has_x(), 0);
    repeat (2) @(negedge Clk);
    check("wrap_pc0b", pc, 0);
    check("wrap_nox2", has_x(), 0);
    check("wrap_busy", busy, 1);
    reset = 1'b1;
    @(negedge Clk);
    reset = 1'b0;

    // reset asserted in the middle of the ADD execute cycle
    for (int i = 0; i < 16; i++) rom[i] = tv[0].rom[i];
    pulse_start();
    repeat (3) @(negedge Clk);
    check("midadd_cmd", command, 3'b011);
    check("midadd_en", {En, En1, busy}, 3'b111);
    #2;
    reset = 1'b1;
    #1;
    check("async_en", {En, En1, busy}, 0);
    check("async_pc", pc, 0);
    @(negedge Clk);
    reset = 1'b0;
    repeat (2) @(negedge Clk);
    check("post_rst_idle", busy, 0);
    run_prog(0, 0);

    // start pulsed during execute of ADD must be ignored
    run_prog(0, 3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
